// File: rtl/rdbk_pkg.sv
// Shared definitions for the RAM readback checker: FSM encoding and the test pattern,
// which the writer-side generator also uses so both ends agree on the expected data.
package rdbk_pkg;

  localparam int PAT_W = 64;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Callers zero-extend their operands and keep the low DATA_WIDTH bits of the result.
  function automatic logic [PAT_W-1:0] expected(input logic [PAT_W-1:0] seed,
                                                input logic [PAT_W-1:0] addr);
    return seed ^ addr;
  endfunction

endpackage

// File: rtl/rdbk_delay_pipe.sv
// Valid + address shift register that tracks reads in flight through the RAM.
module rdbk_delay_pipe #(
  parameter int DEPTH      = 1,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [ADDR_WIDTH-1:0] in_addr,
  output logic                  out_valid,
  output logic [ADDR_WIDTH-1:0] out_addr
);

  logic [DEPTH-1:0]      valid_q;
  logic [ADDR_WIDTH-1:0] addr_q [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) addr_q[i] <= '0;
    end else begin
      valid_q[0] <= in_valid;
      addr_q[0]  <= in_addr;
      for (int i = 1; i < DEPTH; i++) begin
        valid_q[i] <= valid_q[i-1];
        addr_q[i]  <= addr_q[i-1];
      end
    end
  end

  assign out_valid = valid_q[DEPTH-1];
  assign out_addr  = addr_q[DEPTH-1];

endmodule

// File: rtl/ram_readback_checker.sv
// Sweeps a RAM read port over 0..last_addr and checks each word against seed ^ addr.
// Define RDBK_FAIL_CAPTURE_EN to record the address/data of the first mismatch.
//
// state | meaning
// IDLE  | waiting for i_start
// READ  | one read per cycle, counter advances until last_addr is issued
// DRAIN | RD_LATENCY cycles letting in-flight compares finish
// DONE  | one-cycle o_done pulse, o_pass reflects the final error count
module ram_readback_checker
  import rdbk_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDR_WIDTH    = 16,
  parameter int RD_LATENCY    = 1,
  parameter int ERR_CNT_WIDTH = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_start,
  input  logic [DATA_WIDTH-1:0]    i_seed,
  input  logic [ADDR_WIDTH-1:0]    i_last_addr,
  output logic [ADDR_WIDTH-1:0]    o_ram_addr,
  output logic                     o_ram_re,
  input  logic [DATA_WIDTH-1:0]    i_ram_rdata,
  output logic                     o_busy,
  output logic                     o_done,
  output logic                     o_pass,
  output logic [ERR_CNT_WIDTH-1:0] o_err_cnt,
  output logic [ADDR_WIDTH-1:0]    o_first_err_addr,
  output logic [DATA_WIDTH-1:0]    o_first_err_data
);

  state_t                   state_q, state_d;
  logic [ADDR_WIDTH-1:0]    addr_q;
  logic [ADDR_WIDTH-1:0]    last_q;
  logic [DATA_WIDTH-1:0]    seed_q;
  logic [1:0]               drain_q;
  logic [ERR_CNT_WIDTH-1:0] err_q;
  logic                     pass_q;
  logic                     start_ok;
  logic                     last_issue;
  logic                     cmp_valid;
  logic [ADDR_WIDTH-1:0]    cmp_addr;
  logic [DATA_WIDTH-1:0]    exp_word;
  logic                     mismatch;

  assign start_ok   = (state_q == S_IDLE) && i_start;
  assign last_issue = (addr_q == last_q);

  rdbk_delay_pipe #(
    .DEPTH      (RD_LATENCY),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_pipe (
    .clk       (i_clk),
    .rst       (i_rst),
    .in_valid  (o_ram_re),
    .in_addr   (addr_q),
    .out_valid (cmp_valid),
    .out_addr  (cmp_addr)
  );

  assign exp_word = DATA_WIDTH'(expected(PAT_W'(seed_q), PAT_W'(cmp_addr)));
  assign mismatch = cmp_valid && (i_ram_rdata != exp_word);

  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (i_start) state_d = S_READ;
      S_READ:  if (last_issue) state_d = S_DRAIN;
      S_DRAIN: if (drain_q == '0) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    o_ram_re = 1'b0;
    o_busy   = 1'b0;
    o_done   = 1'b0;
    o_pass   = pass_q;
    case (state_q)
      S_READ:  begin o_ram_re = 1'b1; o_busy = 1'b1; end
      S_DRAIN: o_busy = 1'b1;
      S_DONE:  begin o_done = 1'b1; o_pass = (err_q == '0); end
      default: ;
    endcase
  end

  // The sweep ends on counter == last_q, so an all-ones last_addr never relies on wrap.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      addr_q  <= '0;
      last_q  <= '0;
      seed_q  <= '0;
      drain_q <= '0;
      err_q   <= '0;
      pass_q  <= 1'b0;
    end else begin
      if (start_ok) begin
        addr_q <= '0;
        last_q <= i_last_addr;
        seed_q <= i_seed;
        err_q  <= '0;
        pass_q <= 1'b0;
      end
      if (state_q == S_READ) begin
        if (last_issue) drain_q <= 2'(RD_LATENCY - 1);
        else            addr_q  <= addr_q + 1'b1;
      end
      if (state_q == S_DRAIN && drain_q != '0) drain_q <= drain_q - 1'b1;
      if (mismatch && err_q != '1) err_q <= err_q + 1'b1;
      if (state_q == S_DONE) pass_q <= (err_q == '0);
    end
  end

  assign o_ram_addr = addr_q;
  assign o_err_cnt  = err_q;

`ifdef RDBK_FAIL_CAPTURE_EN
  logic [ADDR_WIDTH-1:0] first_addr_q;
  logic [DATA_WIDTH-1:0] first_data_q;

  // err_q is still zero exactly when this is the first mismatch of the sweep.
  always_ff @(posedge i_clk) begin
    if (i_rst || start_ok) begin
      first_addr_q <= '0;
      first_data_q <= '0;
    end else if (mismatch && err_q == '0) begin
      first_addr_q <= cmp_addr;
      first_data_q <= i_ram_rdata;
    end
  end

  assign o_first_err_addr = first_addr_q;
  assign o_first_err_data = first_data_q;
`else
  assign o_first_err_addr = '0;
  assign o_first_err_data = '0;
`endif

endmodule

// File: tb/tb_ram_readback_checker.sv
// Bench for ram_readback_checker: two instances (latency 1 / 16-bit address, latency 2 /
// 4-bit address with 4-bit error counter) checked every cycle against a sweep-level model.
module tb_ram_readback_checker;

`ifdef RDBK_FAIL_CAPTURE_EN
  localparam bit CAP = 1'b1;
`else
  localparam bit CAP = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // instance 0
  logic        rst0 = 1'b1, start0 = 1'b0;
  logic [7:0]  seed0 = '0;
  logic [15:0] last0 = '0;
  logic [15:0] raddr0, err0, fea0;
  logic        re0, busy0, done0, pass0;
  logic [7:0]  rdata0, fed0;
  // instance 1
  logic        rst1 = 1'b1, start1 = 1'b0;
  logic [7:0]  seed1 = '0;
  logic [3:0]  last1 = '0;
  logic [3:0]  raddr1, err1, fea1;
  logic        re1, busy1, done1, pass1;
  logic [7:0]  rdata1, fed1;

  ram_readback_checker #(.DATA_WIDTH(8), .ADDR_WIDTH(16), .RD_LATENCY(1), .ERR_CNT_WIDTH(16)) u_dut0 (
    .i_clk(clk), .i_rst(rst0), .i_start(start0), .i_seed(seed0), .i_last_addr(last0),
    .o_ram_addr(raddr0), .o_ram_re(re0), .i_ram_rdata(rdata0), .o_busy(busy0), .o_done(done0),
    .o_pass(pass0), .o_err_cnt(err0), .o_first_err_addr(fea0), .o_first_err_data(fed0));

  ram_readback_checker #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .RD_LATENCY(2), .ERR_CNT_WIDTH(4)) u_dut1 (
    .i_clk(clk), .i_rst(rst1), .i_start(start1), .i_seed(seed1), .i_last_addr(last1),
    .o_ram_addr(raddr1), .o_ram_re(re1), .i_ram_rdata(rdata1), .o_busy(busy1), .o_done(done1),
    .o_pass(pass1), .o_err_cnt(err1), .o_first_err_addr(fea1), .o_first_err_data(fed1));

  // RAM models with the matching read latency
  logic [7:0] mem [2][64];
  logic [7:0] q0, q1a, q1b;
  always @(posedge clk) begin
    if (re0) q0 <= mem[0][raddr0[5:0]];
    if (re1) q1a <= mem[1][{2'b00, raddr1}];
    q1b <= q1a;
  end
  assign rdata0 = q0;
  assign rdata1 = q1b;

  // normalised views
  logic        n_rst[2], n_start[2], n_re[2], n_busy[2], n_done[2], n_pass[2];
  logic [7:0]  n_seed[2], n_fed[2];
  logic [15:0] n_last[2], n_addr[2], n_err[2], n_fea[2];
  assign n_rst[0] = rst0;    assign n_rst[1] = rst1;
  assign n_start[0] = start0; assign n_start[1] = start1;
  assign n_seed[0] = seed0;  assign n_seed[1] = seed1;
  assign n_last[0] = last0;  assign n_last[1] = {12'b0, last1};
  assign n_addr[0] = raddr0; assign n_addr[1] = {12'b0, raddr1};
  assign n_re[0] = re0;      assign n_re[1] = re1;
  assign n_busy[0] = busy0;  assign n_busy[1] = busy1;
  assign n_done[0] = done0;  assign n_done[1] = done1;
  assign n_pass[0] = pass0;  assign n_pass[1] = pass1;
  assign n_err[0] = err0;    assign n_err[1] = {12'b0, err1};
  assign n_fea[0] = fea0;    assign n_fea[1] = {12'b0, fea1};
  assign n_fed[0] = fed0;    assign n_fed[1] = fed1;

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      if (failures < 40) $display("FAIL %s[%0d] t=%0t got=%0h expected=%0h", nm, k, $time, act, expv);
    end
  endtask

  // Sweep-level model: offset within the sweep plus the results the sweep must produce
  int rdl[2] = '{1, 2};
  int sat[2] = '{65535, 15};
  int off[2] = '{-1, -1};
  int len[2];
  bit armed[2] = '{1'b0, 1'b0};
  int sw_err[2], sh_err[2];
  logic sh_pass[2];
  logic [15:0] sw_fea[2], sh_fea[2], sh_addr[2], last_v[2];
  logic [7:0] sw_fed[2], sh_fed[2], mw;

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (n_rst[k]) begin
        armed[k] = 1'b1; off[k] = -1;
        sh_err[k] = 0; sh_pass[k] = 1'b0; sh_fea[k] = '0; sh_fed[k] = '0; sh_addr[k] = '0;
      end else if (off[k] < 0) begin
        if (n_start[k]) begin
          off[k] = 1; len[k] = int'(n_last[k]) + 1; last_v[k] = n_last[k];
          sh_err[k] = 0; sh_pass[k] = 1'b0; sh_fea[k] = '0; sh_fed[k] = '0;
          sw_err[k] = 0; sw_fea[k] = '0; sw_fed[k] = '0;
          for (int a = 0; a < len[k]; a++) begin
            mw = mem[k][a];
            if (mw != (n_seed[k] ^ 8'(a))) begin
              if (sw_err[k] == 0 && CAP) begin sw_fea[k] = 16'(a); sw_fed[k] = mw; end
              sw_err[k]++;
            end
          end
          if (sw_err[k] > sat[k]) sw_err[k] = sat[k];
        end
      end else if (off[k] == len[k] + rdl[k] + 1) begin
        off[k] = -1;
        sh_err[k] = sw_err[k]; sh_pass[k] = (sw_err[k] == 0);
        sh_fea[k] = sw_fea[k]; sh_fed[k] = sw_fed[k]; sh_addr[k] = last_v[k];
      end else begin
        off[k]++;
      end
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (armed[k]) begin
        if (off[k] >= 1) begin
          chk("ram_re", k, n_re[k], off[k] <= len[k]);
          if (off[k] <= len[k]) chk("ram_addr", k, n_addr[k], off[k] - 1);
          chk("busy", k, n_busy[k], off[k] <= len[k] + rdl[k]);
          chk("done", k, n_done[k], off[k] == len[k] + rdl[k] + 1);
          if (off[k] == 1) chk("err_clear", k, n_err[k], 0);
          if (off[k] <= len[k] + rdl[k]) chk("pass_clear", k, n_pass[k], 0);
          if (off[k] == len[k] + rdl[k] + 1) begin
            chk("err_final", k, n_err[k], sw_err[k]);
            chk("pass_final", k, n_pass[k], sw_err[k] == 0);
            chk("fea_final", k, n_fea[k], sw_fea[k]);
            chk("fed_final", k, n_fed[k], sw_fed[k]);
          end
        end else begin
          chk("idle_re", k, n_re[k], 0);
          chk("idle_busy", k, n_busy[k], 0);
          chk("idle_done", k, n_done[k], 0);
          chk("idle_err", k, n_err[k], sh_err[k]);
          chk("idle_pass", k, n_pass[k], sh_pass[k]);
          chk("idle_addr", k, n_addr[k], sh_addr[k]);
          chk("idle_fea", k, n_fea[k], sh_fea[k]);
          chk("idle_fed", k, n_fed[k], sh_fed[k]);
        end
      end
    end
  end

  task automatic set_start(input int k, input logic v);
    if (k == 0) start0 = v; else start1 = v;
  endtask

  task automatic set_rst(input int k, input logic v);
    if (k == 0) rst0 = v; else rst1 = v;
  endtask

  // Start a sweep, optionally pulse start again at cycle 'extra' or reset at cycle 'rst_at'.
  task automatic run(input int k, input logic [7:0] sd, input int last, input int extra,
                     input int rst_at, output int done_cyc, output int nre);
    done_cyc = -1; nre = 0;
    if (k == 0) begin seed0 = sd; last0 = 16'(last); end
    else begin seed1 = sd; last1 = 4'(last); end
    set_start(k, 1'b1);
    for (int i = 1; i < 400; i++) begin
      @(negedge clk);
      if (i == 1) set_start(k, 1'b0);
      if (i == extra) set_start(k, 1'b1);
      else if (i == extra + 1) set_start(k, 1'b0);
      if (n_re[k]) nre++;
      if (i == rst_at) set_rst(k, 1'b1);
      if (rst_at > 0 && i == rst_at + 1) begin
        set_rst(k, 1'b0);
        chk("rst_re", k, n_re[k], 0);
        chk("rst_busy", k, n_busy[k], 0);
        chk("rst_done", k, n_done[k], 0);
        chk("rst_pass", k, n_pass[k], 0);
        chk("rst_err", k, n_err[k], 0);
        chk("rst_addr", k, n_addr[k], 0);
        chk("rst_fea", k, n_fea[k], 0);
        chk("rst_fed", k, n_fed[k], 0);
        break;
      end
      if (n_done[k]) begin done_cyc = i; break; end
    end
    @(negedge clk);
    set_start(k, 1'b0);
    if (rst_at <= 0) chk("done_seen", k, done_cyc >= 0, 1);
  endtask

  int dc, nr;

  initial begin
    for (int a = 0; a < 64; a++) begin
      mem[0][a] = 8'h5A ^ 8'(a);
      mem[1][a] = 8'h3C ^ 8'(a);
    end
    repeat (3) @(negedge clk);
    rst0 = 1'b0; rst1 = 1'b0;
    @(negedge clk);
    chk("reset_err", 0, n_err[0], 0);
    chk("reset_pass", 0, n_pass[0], 0);

    // clean sweep 0..15, latency 1
    run(0, 8'h5A, 15, -1, -1, dc, nr);
    chk("t1_done_cycle", 0, dc, 18);
    chk("t1_reads", 0, nr, 16);
    chk("t1_err", 0, n_err[0], 0);
    chk("t1_pass", 0, n_pass[0], 1);

    // two corrupted words
    mem[0][7] = 8'h00;
    mem[0][9] = 8'hFF;
    run(0, 8'h5A, 15, -1, -1, dc, nr);
    chk("t2_err", 0, n_err[0], 2);
    chk("t2_pass", 0, n_pass[0], 0);
    chk("t2_fea", 0, n_fea[0], CAP ? 7 : 0);
    chk("t2_fed", 0, n_fed[0], 0);
    mem[0][7] = 8'h5A ^ 8'd7;
    mem[0][9] = 8'h5A ^ 8'd9;

    // wrong seed: every one of 32 words mismatches
    run(0, 8'hA5, 31, -1, -1, dc, nr);
    chk("t_seed_err", 0, n_err[0], 32);
    chk("t_seed_fed", 0, n_fed[0], CAP ? 8'h5A : 8'h00);

    // reset mid-sweep, then a clean 64-word sweep
    run(0, 8'h5A, 63, -1, 5, dc, nr);
    run(0, 8'h5A, 63, -1, -1, dc, nr);
    chk("t5_done_cycle", 0, dc, 66);
    chk("t5_pass", 0, n_pass[0], 1);

    // reset and start together: reset wins
    set_rst(0, 1'b1); set_start(0, 1'b1);
    @(negedge clk);
    set_rst(0, 1'b0); set_start(0, 1'b0);
    chk("rst_prio_busy", 0, n_busy[0], 0);
    @(negedge clk);
    chk("rst_prio_busy2", 0, n_busy[0], 0);

    // latency 2, single read, extra start during DRAIN and during DONE
    run(1, 8'h3C, 0, 2, -1, dc, nr);
    chk("t3_done_cycle", 1, dc, 4);
    chk("t3_reads", 1, nr, 1);
    chk("t3_pass", 1, n_pass[1], 1);
    run(1, 8'h3C, 0, 4, -1, dc, nr);
    chk("t3b_busy_after", 1, n_busy[1], 0);

    // full 4-bit address sweep
    run(1, 8'h3C, 15, -1, -1, dc, nr);
    chk("t6_done_cycle", 1, dc, 19);
    chk("t6_reads", 1, nr, 16);
    chk("t6_pass", 1, n_pass[1], 1);
    repeat (3) @(negedge clk);
    chk("t6_no_redone", 1, n_done[1], 0);

    // all words wrong: 4-bit counter saturates
    for (int a = 0; a < 16; a++) mem[1][a] = ~(8'h3C ^ 8'(a));
    run(1, 8'h3C, 15, -1, -1, dc, nr);
    chk("t4_err_sat", 1, n_err[1], 15);
    chk("t4_pass", 1, n_pass[1], 0);
    chk("t4_fed", 1, n_fed[1], CAP ? 8'hC3 : 8'h00);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
